fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, instruction and data width in bits.
REQ-002 Parameter PC_WIDTH, 9, program counter width in bits (byte address).
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, 0, first fetch address after reset.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 imem_req  output  1  instruction memory read strobe, combinational.
REQ-008 imem_address  output  PC_WIDTH-2  word address (fetch PC >> 2), combinational.
REQ-009 imem_q  input  XLEN  read data, valid exactly one cycle after imem_req.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  PC_WIDTH  redirect target byte address.
REQ-012 inst_valid  output  1  queue head holds an instruction.
REQ-013 inst_data  output  XLEN  queue head instruction.
REQ-014 inst_pc  output  PC_WIDTH  queue head PC.
REQ-015 inst_ready  input  1  decode accepts head this cycle (driven as !stall).
REQ-016 occupancy  output  $clog2(DEPTH)+1  current queue entry count.

Function
REQ-017 The block SHALL hold a fetch PC register, a DEPTH-entry circular queue of {instruction, PC}, and one in-flight flag plus in-flight PC register.
REQ-018 Pop SHALL occur when inst_valid && inst_ready; inst_ready with an empty queue SHALL have no effect.
REQ-019 Issue SHALL occur (imem_req=1) when reset is high and occupancy + inflight - pop < DEPTH, or when redirect_valid=1.
REQ-020 imem_address SHALL be redirect_pc[PC_WIDTH-1:2] when redirect_valid=1, else fetch PC[PC_WIDTH-1:2].
REQ-021 On issue the fetch PC SHALL become issued PC + 4, modulo 2^PC_WIDTH (wrap to 0 permitted), and the in-flight flag SHALL set with the issued PC stored.
REQ-022 A response (in-flight flag set at cycle start) SHALL push {imem_q, in-flight PC} at the queue tail unless redirect_valid=1 in that cycle; the flag clears unless a new issue occurs.
REQ-023 Simultaneous push and pop SHALL both take effect, occupancy unchanged; push when occupancy=DEPTH SHALL never occur by construction of REQ-019.
REQ-024 redirect_valid=1 SHALL, in the same cycle: empty the queue (occupancy 0 next cycle), discard any arriving response, cancel the old in-flight request, and issue at redirect_pc; a simultaneous pop SHALL be discarded with the flush.
REQ-025 redirect_pc[1:0] SHALL be ignored (treated as 00).
REQ-026 Latency: issue at cycle t -> entry visible on inst_* at t+2; redirect at t -> first target instruction on inst_valid at t+2.
REQ-027 Steady state with inst_ready=1 continuously SHALL sustain one instruction per cycle.
REQ-028 inst_data/inst_pc SHALL be registered queue-head outputs; with inst_valid=0 their values are don't-care except after reset.
REQ-029 Queue head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 With reset=0 at a rising edge: fetch PC=RESET_PC, occupancy=0, in-flight=0, inst_valid=0, inst_data=0, inst_pc=0, pointers=0.
REQ-031 While reset=0, imem_req SHALL be 0 and redirect_valid SHALL be ignored.
REQ-032 Reset asserted mid-operation SHALL discard queue contents and any in-flight response in that same edge.
REQ-033 First cycle after reset release SHALL issue at RESET_PC.

Verification
REQ-034 Reset release, inst_ready=1, imem_q=word(addr) -> inst_valid from cycle 2, inst_pc sequence 0,4,8,12..., one per cycle.
REQ-035 inst_ready=0 from release, DEPTH=4 -> exactly 4 issues (addr 0..3), occupancy saturates at 4, imem_req stays 0; inst_ready=1 then drains 0,4,8,12 and fetching resumes at 16.
REQ-036 Queue full, redirect_valid=1 with redirect_pc=0x40 -> occupancy 0 next cycle, imem_address=0x10 in redirect cycle, next inst_pc=0x40 two cycles later, no stale entry emitted.
REQ-037 Redirect in the cycle a response arrives (in-flight PC 0x08) -> 0x08 never appears on inst_pc; redirect_pc=0x43 fetches 0x40.
REQ-038 PC_WIDTH=9 and fetch reaches 0x1FC -> next inst_pc 0x000 after 0x1FC.
REQ-039 reset=0 for one cycle while occupancy=3 and inflight=1 -> inst_valid=0, occupancy=0 next cycle, first post-reset inst_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to instruction memory and buffers the
// returned instructions with their PCs in a small circular prefetch queue for decode.
module fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          PC_WIDTH = 9,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [PC_WIDTH-3:0]     imem_address,
  input  logic [XLEN-1:0]         imem_q,
  input  logic                    redirect_valid,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    inst_valid,
  output logic [XLEN-1:0]         inst_data,
  output logic [PC_WIDTH-1:0]     inst_pc,
  input  logic                    inst_ready,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_q   [DEPTH];

  logic [PC_WIDTH-1:0] issue_pc;
  logic                issue;
  logic                push;
  logic                pop;

  always_comb begin
    inst_valid = (count_q != '0);
    pop        = reset & inst_valid & inst_ready;
    // A response landing in a redirect cycle belongs to the abandoned path.
    push       = reset & inflight_q & ~redirect_valid;
    issue_pc   = redirect_valid ? {redirect_pc[PC_WIDTH-1:2], 2'b00} : fetch_pc_q;
    // Reserve a slot for the request still in flight so a push can never overflow.
    issue      = reset & (redirect_valid |
                 ((SW'(count_q) + SW'(inflight_q)) < (SW'(DEPTH) + SW'(pop))));

    imem_req      = issue;
    imem_address  = issue_pc[PC_WIDTH-1:2];

    fetch_pc_d    = issue ? (issue_pc + PC_WIDTH'(4)) : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_pc : inflight_pc_q;

    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  assign inst_data = data_q[head_q];
  assign inst_pc   = pc_q[head_q];
  assign occupancy = count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if (push) begin
        data_q[tail_q] <= imem_q;
        pc_q[tail_q]   <= inflight_pc_q;
      end
    end
  end

endmodule
